// File: rtl/seq_timer_pkg.sv
// seq_timer_pkg
//   Shared definitions for the micro-step sequencer and the control unit:
//   the sequencer FSM state encoding and the T0..T3 step codes.
package seq_timer_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_END  = 2'd2,
        ST_DONE = 2'd3
    } state_t;

    localparam logic [1:0] T0 = 2'b00;
    localparam logic [1:0] T1 = 2'b01;
    localparam logic [1:0] T2 = 2'b10;
    localparam logic [1:0] T3 = 2'b11;

    // Next micro-step; T3 wraps back to T0.
    function automatic logic [1:0] next_step(input logic [1:0] t);
        return t + 2'd1;
    endfunction

endpackage

// File: rtl/seq_timer.sv
// seq_timer
//   Micro-step sequencer. After an accepted start it walks T0..T3 once per
//   pass for n_iter passes, then raises E for one cycle (END) and done for
//   one cycle (DONE) before returning to IDLE. All outputs are registered.
//
// Ports
//   clk      in   system clock, rising edge
//   rst      in   synchronous active-high reset
//   start    in   begin a run (sampled in IDLE only)
//   n_iter   in   pass count, captured on an accepted start
//   stall    in   freezes step / pass progress while in RUN
//   T        out  current micro-step (00=T0 .. 11=T3)
//   E        out  end-of-run strobe, high only in END
//   busy     out  high in RUN and END
//   done     out  one-cycle completion pulse
//   iter_cnt out  completed passes in the current run
module seq_timer
    import seq_timer_pkg::*;
#(
    parameter int unsigned ITER_W = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [ITER_W-1:0] n_iter,
    input  logic              stall,
    output logic [1:0]        T,
    output logic              E,
    output logic              busy,
    output logic              done,
    output logic [ITER_W-1:0] iter_cnt
);

    state_t            state;
    logic [ITER_W-1:0] n_lat;
    logic [ITER_W-1:0] iter_next;

    assign iter_next = iter_cnt + 1'b1;

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= ST_IDLE;
            T        <= T0;
            E        <= 1'b0;
            busy     <= 1'b0;
            done     <= 1'b0;
            iter_cnt <= '0;
            n_lat    <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    T    <= T0;
                    E    <= 1'b0;
                    done <= 1'b0;
                    busy <= 1'b0;
                    if (start) begin
                        n_lat    <= n_iter;
                        iter_cnt <= '0;
                        busy     <= 1'b1;
                        // A zero-pass run still issues the E strobe.
                        if (n_iter == '0) begin
                            state <= ST_END;
                            E     <= 1'b1;
                        end else begin
                            state <= ST_RUN;
                        end
                    end
                end
                ST_RUN: begin
                    if (!stall) begin
                        T <= next_step(T);
                        if (T == T3) begin
                            iter_cnt <= iter_next;
                            if (iter_next == n_lat) begin
                                state <= ST_END;
                                E     <= 1'b1;
                            end
                        end
                    end
                end
                ST_END: begin
                    T     <= T0;
                    E     <= 1'b0;
                    busy  <= 1'b0;
                    done  <= 1'b1;
                    state <= ST_DONE;
                end
                ST_DONE: begin
                    done  <= 1'b0;
                    state <= ST_IDLE;
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

    a_e_done_excl: assert property (@(posedge clk) disable iff (rst) !(E && done));
    a_e_one_cycle: assert property (@(posedge clk) disable iff (rst) E |=> !E);
    a_busy_state:  assert property (@(posedge clk) disable iff (rst)
                                    busy == (state == ST_RUN || state == ST_END));
    a_e_in_end:    assert property (@(posedge clk) disable iff (rst) E == (state == ST_END));

endmodule

// File: tb/tb_seq_timer.sv
module tb_seq_timer;
    import seq_timer_pkg::*;

    localparam int unsigned ITER_W = 4;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              start = 1'b0;
    logic [ITER_W-1:0] n_iter = '0;
    logic              stall = 1'b0;
    logic [1:0]        T;
    logic              E;
    logic              busy;
    logic              done;
    logic [ITER_W-1:0] iter_cnt;

    seq_timer #(.ITER_W(ITER_W)) dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .n_iter   (n_iter),
        .stall    (stall),
        .T        (T),
        .E        (E),
        .busy     (busy),
        .done     (done),
        .iter_cnt (iter_cnt)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [1:0]        t;
        logic              e;
        logic              b;
        logic              d;
        logic [ITER_W-1:0] i;
        string             name;
        int                idx;
    } exp_t;

    exp_t  sb[$];
    int    n_checks = 0;
    int    n_pass   = 0;
    string phase    = "init";
    int    cyc_no   = 0;

    // Drive one cycle of inputs and record the outputs expected after the edge.
    task automatic cyc(input logic r, input logic s, input logic [ITER_W-1:0] n,
                       input logic st, input logic [1:0] et, input logic ee,
                       input logic eb, input logic ed, input logic [ITER_W-1:0] ei);
        exp_t x;
        @(negedge clk);
        rst = r; start = s; n_iter = n; stall = st;
        x.t = et; x.e = ee; x.b = eb; x.d = ed; x.i = ei;
        x.name = phase; x.idx = cyc_no;
        sb.push_back(x);
        cyc_no++;
        @(posedge clk);
    endtask

    // Plain run of n (>0) passes, no stall. s_mid / n_mid are driven on every
    // cycle after the start, up to and including the edge that leaves DONE.
    task automatic run(input int n, input logic s_mid, input logic [ITER_W-1:0] n_mid);
        cyc(0, 1, ITER_W'(n), 0, T0, 0, 1, 0, '0);
        for (int p = 0; p < n; p++)
            for (int t = 0; t < 4; t++)
                if (!(p == 0 && t == 0))
                    cyc(0, s_mid, n_mid, 0, 2'(t), 0, 1, 0, ITER_W'(p));
        cyc(0, s_mid, n_mid, 0, T0, 1, 1, 0, ITER_W'(n));   // END
        cyc(0, s_mid, n_mid, 0, T0, 0, 0, 1, ITER_W'(n));   // DONE
        cyc(0, s_mid, n_mid, 0, T0, 0, 0, 0, ITER_W'(n));   // IDLE, start ignored in DONE
        cyc(0, 0, '0, 0, T0, 0, 0, 0, ITER_W'(n));          // stays IDLE
    endtask

    // Monitor: every cycle the DUT presents its registered outputs; compare
    // against the oldest expected entry.
    always @(posedge clk) begin
        #1;
        if (sb.size() != 0) begin
            exp_t x;
            x = sb.pop_front();
            n_checks++;
            if (T === x.t && E === x.e && busy === x.b && done === x.d && iter_cnt === x.i)
                n_pass++;
            else
                $display("FAIL %s[%0d]: got T=%b E=%b busy=%b done=%b iter=%0d, want T=%b E=%b busy=%b done=%b iter=%0d",
                         x.name, x.idx, T, E, busy, done, iter_cnt, x.t, x.e, x.b, x.d, x.i);
        end
    end

    initial begin
        phase = "reset";
        cyc(1, 1, 4'd5, 1, T0, 0, 0, 0, '0);
        cyc(1, 0, '0, 0, T0, 0, 0, 0, '0);
        cyc(0, 0, '0, 0, T0, 0, 0, 0, '0);

        phase = "n2";
        run(2, 0, 4'd2);

        phase = "stall";
        cyc(0, 1, 4'd1, 0, T0, 0, 1, 0, 4'd0);
        cyc(0, 0, 4'd1, 0, T1, 0, 1, 0, 4'd0);
        cyc(0, 0, 4'd1, 0, T2, 0, 1, 0, 4'd0);
        cyc(0, 0, 4'd1, 1, T2, 0, 1, 0, 4'd0);
        cyc(0, 0, 4'd1, 1, T2, 0, 1, 0, 4'd0);
        cyc(0, 0, 4'd1, 1, T2, 0, 1, 0, 4'd0);
        cyc(0, 0, 4'd1, 0, T3, 0, 1, 0, 4'd0);
        cyc(0, 0, 4'd1, 0, T0, 1, 1, 0, 4'd1);   // END
        cyc(0, 0, 4'd1, 1, T0, 0, 0, 1, 4'd1);   // stall ignored in END
        cyc(0, 0, 4'd1, 1, T0, 0, 0, 0, 4'd1);

        phase = "zero";
        cyc(0, 1, 4'd0, 0, T0, 1, 1, 0, 4'd0);   // iter_cnt cleared, E next cycle
        cyc(0, 0, 4'd0, 0, T0, 0, 0, 1, 4'd0);
        cyc(0, 0, 4'd0, 0, T0, 0, 0, 0, 4'd0);

        phase = "ignore";
        run(3, 1, 4'd1);

        phase = "rst_run";
        cyc(0, 1, 4'd2, 0, T0, 0, 1, 0, 4'd0);
        cyc(0, 0, 4'd2, 0, T1, 0, 1, 0, 4'd0);
        cyc(0, 0, 4'd2, 0, T2, 0, 1, 0, 4'd0);
        cyc(0, 0, 4'd2, 0, T3, 0, 1, 0, 4'd0);
        cyc(0, 0, 4'd2, 0, T0, 0, 1, 0, 4'd1);
        cyc(0, 0, 4'd2, 0, T1, 0, 1, 0, 4'd1);
        cyc(0, 0, 4'd2, 0, T2, 0, 1, 0, 4'd1);
        cyc(1, 1, 4'd2, 0, T0, 0, 0, 0, 4'd0);
        cyc(0, 0, 4'd2, 0, T0, 0, 0, 0, 4'd0);
        cyc(0, 0, 4'd2, 0, T0, 0, 0, 0, 4'd0);
        phase = "after_rst";
        run(1, 0, 4'd0);

        phase = "rst_end";
        cyc(0, 1, 4'd0, 0, T0, 1, 1, 0, 4'd0);
        cyc(1, 0, 4'd0, 0, T0, 0, 0, 0, 4'd0);   // no done after reset in END
        cyc(0, 0, 4'd0, 0, T0, 0, 0, 0, 4'd0);

        @(negedge clk);
        start = 0; rst = 0; stall = 0;
        for (int k = 0; k < 20 && sb.size() != 0; k++) @(negedge clk);
        if (sb.size() != 0) begin
            n_checks++;
            $display("FAIL drain: got %0d pending entries, want 0", sb.size());
        end
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: got no completion, want completion before 100000");
        $fatal(1, "timeout");
    end

endmodule
